// File: rtl/cp0_irq_sequencer_pkg.sv
// Shared definitions for the CP0 interrupt sequencer: FSM states, CP0 register numbers,
// default handler vector layout.
package cp0_irq_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSave,
      StJump,
      StService,
      StReturn
   } state_e;

   typedef enum logic [4:0] {
      Cp0Status = 5'd12,
      Cp0Cause  = 5'd13,
      Cp0Epc    = 5'd14
   } cp0_reg_e;

   localparam logic [31:0] DefHandlerBase = 32'h0000_0800;
   localparam logic [31:0] DefVecStride   = 32'h0000_0010;

endpackage

// File: rtl/cp0_irq_sequencer_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module cp0_irq_sequencer_prio_enc #(
   parameter int unsigned N = 3,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [W-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/cp0_irq_sequencer.sv
// Interrupt entry/exit sequencer: edge-detects requests, holds them pending, and drives the
// CP0 EPC/IE strobes plus PC redirects for handler entry and ERET.
module cp0_irq_sequencer
   import cp0_irq_sequencer_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      NUM_IRQ      = 3,
   parameter logic [WIDTH-1:0] HANDLER_BASE = WIDTH'(DefHandlerBase),
   parameter logic [WIDTH-1:0] VEC_STRIDE   = WIDTH'(DefVecStride),
   localparam int unsigned     SrcW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               ie_in,
   input  logic               insn_valid,
   input  logic [WIDTH-1:0]   pc_in,
   input  logic               eret,
   output logic               epc_we,
   output logic [WIDTH-1:0]   epc_data,
   output logic               ie_zero,
   output logic               ie_one,
   output logic               redirect,
   output logic [WIDTH-1:0]   redirect_pc,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               busy,
   output logic [SrcW-1:0]    cur_src
);

   state_e             state_q;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] rise;
   logic               enc_valid;
   logic [SrcW-1:0]    enc_idx;

   assign rise = irq_in & ~irq_q;

   cp0_irq_sequencer_prio_enc #(
      .N (NUM_IRQ),
      .W (SrcW)
   ) u_prio_enc (
      .req   (pending_q),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // A rise in the same cycle as its ack keeps the bit pending.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         irq_q     <= '0;
         pending_q <= '0;
      end else begin
         irq_q     <= irq_in;
         pending_q <= (pending_q & ~irq_ack) | rise;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= StIdle;
         epc_we      <= 1'b0;
         epc_data    <= '0;
         ie_zero     <= 1'b0;
         ie_one      <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         irq_ack     <= '0;
         busy        <= 1'b0;
         cur_src     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ie_in && insn_valid && enc_valid) begin
                  state_q  <= StSave;
                  cur_src  <= enc_idx;
                  epc_data <= pc_in;
                  epc_we   <= 1'b1;
                  ie_zero  <= 1'b1;
                  irq_ack  <= NUM_IRQ'(1) << enc_idx;
                  busy     <= 1'b1;
               end
            end
            StSave: begin
               state_q     <= StJump;
               epc_we      <= 1'b0;
               ie_zero     <= 1'b0;
               irq_ack     <= '0;
               redirect    <= 1'b1;
               redirect_pc <= HANDLER_BASE + WIDTH'(cur_src) * VEC_STRIDE;
            end
            StJump: begin
               state_q  <= StService;
               redirect <= 1'b0;
            end
            StService: begin
               if (eret) begin
                  state_q     <= StReturn;
                  ie_one      <= 1'b1;
                  redirect    <= 1'b1;
                  redirect_pc <= epc_data;
               end
            end
            StReturn: begin
               state_q  <= StIdle;
               ie_one   <= 1'b0;
               redirect <= 1'b0;
               busy     <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_irq_sequencer.sv
// Scoreboard bench for cp0_irq_sequencer: expected strobe cycles are queued by the stimulus
// and popped by a monitor whenever the DUT raises epc_we, redirect or ie_one.
module tb_cp0_irq_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic [2:0]  irq_in;
   logic        ie_in;
   logic        insn_valid;
   logic [31:0] pc_in;
   logic        eret;
   logic        epc_we;
   logic [31:0] epc_data;
   logic        ie_zero;
   logic        ie_one;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  irq_ack;
   logic        busy;
   logic [1:0]  cur_src;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        epc_we;
      logic        ie_zero;
      logic        ie_one;
      logic        redirect;
      logic [2:0]  ack;
      logic [31:0] data;
   } ev_t;

   ev_t sb[$];

   cp0_irq_sequencer dut (
      .clk         (clk),
      .clr         (clr),
      .irq_in      (irq_in),
      .ie_in       (ie_in),
      .insn_valid  (insn_valid),
      .pc_in       (pc_in),
      .eret        (eret),
      .epc_we      (epc_we),
      .epc_data    (epc_data),
      .ie_zero     (ie_zero),
      .ie_one      (ie_one),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .irq_ack     (irq_ack),
      .busy        (busy),
      .cur_src     (cur_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Entry produces a SAVE cycle then a JUMP cycle to the source's vector.
   task automatic expect_entry(input int src, input logic [31:0] pc);
      ev_t s;
      ev_t j;
      s = '{epc_we: 1'b1, ie_zero: 1'b1, ie_one: 1'b0, redirect: 1'b0,
            ack: 3'(1 << src), data: pc};
      j = '{epc_we: 1'b0, ie_zero: 1'b0, ie_one: 1'b0, redirect: 1'b1,
            ack: 3'b000, data: 32'h0000_0800 + 32'(src) * 32'h10};
      sb.push_back(s);
      sb.push_back(j);
   endtask

   task automatic expect_return(input logic [31:0] pc);
      ev_t r;
      r = '{epc_we: 1'b0, ie_zero: 1'b0, ie_one: 1'b1, redirect: 1'b1,
            ack: 3'b000, data: pc};
      sb.push_back(r);
   endtask

   task automatic pulse_eret();
      eret = 1'b1;
      step(1);
      eret = 1'b0;
   endtask

   // Monitor: every strobe cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!clr && (epc_we || redirect || ie_one)) begin
         ev_t act;
         ev_t exp;
         act = '{epc_we: epc_we, ie_zero: ie_zero, ie_one: ie_one, redirect: redirect,
                 ack: irq_ack, data: (epc_we ? epc_data : redirect_pc)};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got we=%b iz=%b io=%b rd=%b ack=%b data=%h, expected none",
                     act.epc_we, act.ie_zero, act.ie_one, act.redirect, act.ack, act.data);
         end else begin
            exp = sb.pop_front();
            if (act !== exp || busy !== 1'b1)
               begin
                  errors++;
                  $display("FAIL strobe_event: got we=%b iz=%b io=%b rd=%b ack=%b data=%h busy=%b, expected we=%b iz=%b io=%b rd=%b ack=%b data=%h busy=1",
                           act.epc_we, act.ie_zero, act.ie_one, act.redirect, act.ack, act.data,
                           busy, exp.epc_we, exp.ie_zero, exp.ie_one, exp.redirect, exp.ack,
                           exp.data);
               end
         end
      end
   end

   initial begin
      int budget;
      clr        = 1'b1;
      irq_in     = 3'b000;
      ie_in      = 1'b0;
      insn_valid = 1'b0;
      pc_in      = '0;
      eret       = 1'b0;
      #3;
      check("reset_outputs", {epc_we, ie_zero, ie_one, redirect, irq_ack, busy, cur_src},
            32'd0);
      check("reset_epc_data", epc_data, 32'd0);
      check("reset_redirect_pc", redirect_pc, 32'd0);
      step(2);
      clr = 1'b0;
      ie_in = 1'b1;
      insn_valid = 1'b1;
      step(1);

      // Single request on source 1.
      pc_in = 32'h0000_0104;
      expect_entry(1, 32'h0000_0104);
      irq_in = 3'b010;
      step(5);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_cur_src", 32'(cur_src), 32'd1);
      expect_return(32'h0000_0104);
      pulse_eret();
      step(2);
      check("t1_idle", 32'(busy), 32'd0);
      irq_in = 3'b000;
      step(1);

      // Simultaneous rises are serviced in index order, back to back.
      pc_in = 32'h0000_0200;
      expect_entry(0, 32'h0000_0200);
      irq_in = 3'b111;
      step(5);
      check("t2_src0", 32'(cur_src), 32'd0);
      expect_return(32'h0000_0200);
      pc_in = 32'h0000_0300;
      expect_entry(1, 32'h0000_0300);
      pulse_eret();
      step(6);
      check("t2_src1", 32'(cur_src), 32'd1);
      expect_return(32'h0000_0300);
      pc_in = 32'h0000_0400;
      expect_entry(2, 32'h0000_0400);
      pulse_eret();
      step(6);
      check("t2_src2", 32'(cur_src), 32'd2);
      expect_return(32'h0000_0400);
      pulse_eret();
      step(3);
      check("t2_idle", 32'(busy), 32'd0);
      irq_in = 3'b000;
      step(1);

      // IE low: request stays pending with no activity.
      ie_in = 1'b0;
      pc_in = 32'h0000_0500;
      irq_in = 3'b100;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("t3_quiet", 32'({busy, epc_we}), 32'd0);
      end
      expect_entry(2, 32'h0000_0500);
      ie_in = 1'b1;
      step(5);
      check("t3_src2", 32'(cur_src), 32'd2);
      expect_return(32'h0000_0500);
      pulse_eret();
      step(3);
      irq_in = 3'b000;
      step(1);

      // Higher-priority rise during service waits for RETURN.
      pc_in = 32'h0000_0600;
      expect_entry(1, 32'h0000_0600);
      irq_in = 3'b010;
      step(5);
      irq_in = 3'b011;
      step(5);
      check("t4_still_src1", 32'({busy, cur_src}), 32'b101);
      expect_return(32'h0000_0600);
      pc_in = 32'h0000_0700;
      expect_entry(0, 32'h0000_0700);
      pulse_eret();
      step(6);
      check("t4_src0", 32'(cur_src), 32'd0);
      expect_return(32'h0000_0700);
      pulse_eret();
      step(3);
      irq_in = 3'b000;
      step(1);

      // ERET in IDLE and in JUMP is ignored.
      pulse_eret();
      step(3);
      check("t5_idle_eret", 32'({busy, ie_one}), 32'd0);
      pc_in = 32'h0000_0900;
      expect_entry(2, 32'h0000_0900);
      irq_in = 3'b100;
      step(3);
      check("t5_in_jump", 32'({redirect, busy}), 32'b11);
      pulse_eret();
      step(3);
      check("t5_still_service", 32'({busy, ie_one}), 32'b10);
      expect_return(32'h0000_0900);
      pulse_eret();
      step(3);
      irq_in = 3'b000;
      step(1);

      // Reset mid-entry abandons it; the JUMP cycle never reaches the monitor.
      pc_in = 32'h0000_0a00;
      begin
         ev_t s;
         s = '{epc_we: 1'b1, ie_zero: 1'b1, ie_one: 1'b0, redirect: 1'b0,
               ack: 3'b001, data: 32'h0000_0a00};
         sb.push_back(s);
      end
      irq_in = 3'b001;
      step(3);
      check("t6_in_jump", 32'(redirect), 32'd1);
      clr = 1'b1;
      #1;
      check("t6_async_clear", 32'({redirect, busy, epc_we, ie_zero, ie_one, irq_ack, cur_src}),
            32'd0);
      check("t6_redirect_pc", redirect_pc, 32'd0);
      irq_in = 3'b000;
      step(2);
      clr = 1'b0;
      step(10);
      check("t6_pending_dropped", 32'(busy), 32'd0);

      budget = 50;
      while (sb.size() != 0 && budget > 0) begin
         step(1);
         budget--;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
